// File: rtl/disp_mode_mux.sv
// rtl/disp_mode_mux.sv - registered seven-segment formatter (binary/hex/decimal) with load/busy/done handshake
module disp_mode_mux #(
    parameter int WIDTH = 14,
    parameter int NDISP = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   value,
    input  logic [1:0]         mode,
    input  logic               lz_blank,
    input  logic               load,
    output logic               busy,
    output logic               done,
    output logic [7*NDISP-1:0] disp
);

    function automatic int dec_digits(input int w);
        logic [63:0] m;
        int          n;
        m = (64'd1 << w) - 64'd1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (m != 64'd0) begin
                n++;
                m = m / 64'd10;
            end
        end
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    localparam int ND = dec_digits(WIDTH);
    localparam int NH = (WIDTH + 3) / 4;
    localparam int CW = $clog2(WIDTH + 1);
    // Padded copies so every display index below NDISP is a legal select
    localparam int BW = imax(WIDTH, NDISP);
    localparam int HW = imax(NH, NDISP);
    localparam int DW = imax(ND, NDISP);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [1:0]         mode_q, mode_d;
    logic               lzb_q, lzb_d;
    logic [4*ND-1:0]    bcd_q, bcd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7*NDISP-1:0] disp_q, disp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [4*ND-1:0]    bcd_adj;
    logic [BW-1:0]      bin_v;
    logic [4*HW-1:0]    hex_v;
    logic [4*DW-1:0]    dec_v;
    int                 hex_msd;
    int                 dec_msd;
    logic               dec_ovf;
    logic [7*NDISP-1:0] disp_new;

    always_comb begin
        bcd_adj = bcd_q;
        for (int j = 0; j < ND; j++) begin
            if (bcd_q[4*j +: 4] >= 4'd5) begin
                bcd_adj[4*j +: 4] = bcd_q[4*j +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_v = '0;
        bin_v[WIDTH-1:0] = val_q;
        hex_v = '0;
        hex_v[WIDTH-1:0] = val_q;
        dec_v = '0;
        dec_v[4*ND-1:0] = bcd_q;
        hex_msd = 0;
        for (int i = 0; i < NH; i++) begin
            if (hex_v[4*i +: 4] != 4'd0) hex_msd = i;
        end
        dec_msd = 0;
        for (int i = 0; i < ND; i++) begin
            if (dec_v[4*i +: 4] != 4'd0) dec_msd = i;
        end
        dec_ovf = (dec_msd >= NDISP);
        disp_new = {NDISP{SEG_BLANK}};
        for (int i = 0; i < NDISP; i++) begin
            case (mode_q)
                2'b00: begin
                    if (i < WIDTH) disp_new[7*i +: 7] = seg7({3'd0, bin_v[i]});
                end
                2'b01: begin
                    if (i < NH && !(lzb_q && i > hex_msd)) disp_new[7*i +: 7] = seg7(hex_v[4*i +: 4]);
                end
                2'b10: begin
                    if (dec_ovf) begin
                        disp_new[7*i +: 7] = SEG_DASH;
                    end else if (i < ND && !(lzb_q && i > dec_msd)) begin
                        disp_new[7*i +: 7] = seg7(dec_v[4*i +: 4]);
                    end
                end
                default: disp_new[7*i +: 7] = SEG_BLANK;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        mode_d  = mode_q;
        lzb_d   = lzb_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    val_d   = value;
                    mode_d  = mode;
                    lzb_d   = lz_blank;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = (mode == 2'b10) ? S_SHIFT : S_WRITE;
                end
            end
            S_SHIFT: begin
                // Double-dabble step: adjust nibbles, then shift the next value bit in
                bcd_d = {bcd_adj[4*ND-2:0], val_q[WIDTH-1]};
                val_d = {val_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_WRITE;
            end
            S_WRITE: begin
                disp_d  = disp_new;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            val_q   <= '0;
            mode_q  <= 2'b00;
            lzb_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= {NDISP{SEG_BLANK}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            lzb_q   <= lzb_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign disp = disp_q;

endmodule
